// File: rtl/signmag_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : signmag_seq_divider                                              |
// | Brief   : Sequential restoring divider on sign-magnitude operands, one     |
// |           quotient bit per clock. Optional macro SIGNMAG_DIV_UNIT_FAST_EN  |
// |           lets a unit divisor bypass the iteration.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module signmag_seq_divider #(
   parameter int DVD_W = 14,
   parameter int DVS_W = 7
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [DVD_W:0]   dividend,
   input  logic [DVS_W:0]   divisor,
   output logic [DVD_W-1:0] quotient,
   output logic             q_sign,
   output logic [DVS_W-1:0] remainder,
   output logic             r_sign,
   output logic             busy,
   output logic             done,
   output logic             zflag,
   output logic             dbz
);

   localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             dvd_sign_q, dvd_sign_d;
   logic             dvs_sign_q, dvs_sign_d;
   logic [DVS_W-1:0] dvs_mag_q, dvs_mag_d;
   logic [DVS_W-1:0] pr_q, pr_d;
   logic [DVD_W-1:0] qsr_q, qsr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DVD_W-1:0] quotient_q, quotient_d;
   logic             q_sign_q, q_sign_d;
   logic [DVS_W-1:0] remainder_q, remainder_d;
   logic             r_sign_q, r_sign_d;
   logic             zflag_q, zflag_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic             unit_fast;
   logic             short_path;
   logic [DVS_W:0]   pr_shift;
   logic [DVS_W-1:0] pr_sub;
   logic             pr_ge;
   logic [DVS_W-1:0] pr_step;
   logic [DVD_W-1:0] q_step;
   logic             finish;
   logic             fin_dbz;
   logic [DVD_W-1:0] fin_q;
   logic [DVS_W-1:0] fin_r;

`ifdef SIGNMAG_DIV_UNIT_FAST_EN
   assign unit_fast = (divisor[DVS_W-1:0] == DVS_W'(1));
`else
   assign unit_fast = 1'b0;
`endif

   // Zero and (optionally) unit divisors skip RUN and resolve in the LOAD cycle.
   assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign short_path = (divisor[DVS_W-1:0] == '0) || unit_fast;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = short_path ? S_LOAD : S_RUN;
            else       state_d = S_IDLE;
         end
         S_LOAD:  state_d = S_DONE;
         S_RUN:   if (count_q == '0) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_LOAD) || (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // One restoring step; the partial remainder stays below the divisor, so
   // the low DVS_W bits of the subtraction are exact whenever it is taken.
   always_comb begin
      pr_shift = {pr_q, qsr_q[DVD_W-1]};
      pr_ge    = (pr_shift >= {1'b0, dvs_mag_q});
      pr_sub   = pr_shift[DVS_W-1:0] - dvs_mag_q;
      pr_step  = pr_ge ? pr_sub : pr_shift[DVS_W-1:0];
      q_step   = {qsr_q[DVD_W-2:0], pr_ge};
   end

   always_comb begin
      finish  = (state_q == S_LOAD) || ((state_q == S_RUN) && (count_q == '0));
      fin_dbz = (state_q == S_LOAD) && (dvs_mag_q == '0);
      if (state_q == S_LOAD) begin
         fin_q = fin_dbz ? '1 : qsr_q;
         fin_r = '0;
      end else begin
         fin_q = q_step;
         fin_r = pr_step;
      end
   end

   always_comb begin
      dvd_sign_d  = dvd_sign_q;
      dvs_sign_d  = dvs_sign_q;
      dvs_mag_d   = dvs_mag_q;
      pr_d        = pr_q;
      qsr_d       = qsr_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      q_sign_d    = q_sign_q;
      remainder_d = remainder_q;
      r_sign_d    = r_sign_q;
      zflag_d     = zflag_q;
      dbz_d       = dbz_q;
      if (accept) begin
         dvd_sign_d = dividend[DVD_W];
         dvs_sign_d = divisor[DVS_W];
         dvs_mag_d  = divisor[DVS_W-1:0];
         pr_d       = '0;
         qsr_d      = dividend[DVD_W-1:0];
         count_d    = CNT_W'(DVD_W - 1);
         if (!short_path) dbz_d = 1'b0;
      end else if (state_q == S_RUN) begin
         pr_d    = pr_step;
         qsr_d   = q_step;
         count_d = count_q - CNT_W'(1);
      end
      if (finish) begin
         quotient_d  = fin_q;
         remainder_d = fin_r;
         q_sign_d    = !fin_dbz && (dvd_sign_q ^ dvs_sign_q) && (fin_q != '0);
         r_sign_d    = !fin_dbz && dvd_sign_q && (fin_r != '0);
         zflag_d     = (fin_q == '0);
         dbz_d       = fin_dbz;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         dvd_sign_q  <= 1'b0;
         dvs_sign_q  <= 1'b0;
         dvs_mag_q   <= '0;
         pr_q        <= '0;
         qsr_q       <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         q_sign_q    <= 1'b0;
         remainder_q <= '0;
         r_sign_q    <= 1'b0;
         zflag_q     <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         dvd_sign_q  <= dvd_sign_d;
         dvs_sign_q  <= dvs_sign_d;
         dvs_mag_q   <= dvs_mag_d;
         pr_q        <= pr_d;
         qsr_q       <= qsr_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         q_sign_q    <= q_sign_d;
         remainder_q <= remainder_d;
         r_sign_q    <= r_sign_d;
         zflag_q     <= zflag_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient  = quotient_q;
   assign q_sign    = q_sign_q;
   assign remainder = remainder_q;
   assign r_sign    = r_sign_q;
   assign zflag     = zflag_q;
   assign dbz       = dbz_q;

endmodule
`default_nettype wire
